// File: rtl/unsigned_mul_add_seq_pkg.sv
// Shared definitions for the unsigned multiply-add engine: the default operand
// width, the FSM state encoding and the width of the iteration counter.
package unsigned_mul_add_seq_pkg;

   localparam int MUL_ADD_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width needed to index WIDTH iterations; at least one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/unsigned_mul_add_dp.sv
// Datapath of the unsigned multiply-add engine: multiplier/multiplicand shift
// registers, accumulator, iteration counter and the result register.
// The accumulator is 2*WIDTH bits; q*d + r never exceeds 2^(2W) - 2^W, so no
// carry-out is kept.
module unsigned_mul_add_dp
   import unsigned_mul_add_seq_pkg::*;
#(
   parameter int WIDTH = MUL_ADD_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic                 result_load,
   input  logic [WIDTH-1:0]     quotient,
   input  logic [WIDTH-1:0]     divisor,
   input  logic [WIDTH-1:0]     remainder,
   output logic                 last,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CW-1:0]      count;

   // Accumulator value after the current iteration's conditional add; the
   // result register captures it directly so the final add lands in result
   // on the same edge that enters DONE.
   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
   end

   assign last = (count == LAST_COUNT);

   // Operand latch on accept, one shift-add step per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mplier <= '0;
         mcand  <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (load) begin
         mplier <= quotient;
         mcand  <= {{WIDTH{1'b0}}, divisor};
         acc    <= {{WIDTH{1'b0}}, remainder};
         count  <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
      end
   end

   // Result only updates on entry to DONE and holds through a following RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
      end else if (result_load) begin
         result <= acc_next;
      end
   end

endmodule

// File: rtl/unsigned_mul_add_seq.sv
// Unsigned multiply-add engine: result = quotient*divisor + remainder, one
// multiplier bit per clock. Reconstructs a dividend from divider outputs.
// Optional operand-consistency flag enabled by defining MUL_ADD_CHECK_EN.
//
// Handshake: start is accepted on a rising edge only while busy=0 (IDLE or
// DONE); operands are sampled on that edge. busy is high for the WIDTH
// iteration cycles that follow; done then rises with result valid and stays
// high until the next accept. start while busy=1 is ignored. rst has priority
// over start.
module unsigned_mul_add_seq
   import unsigned_mul_add_seq_pkg::*;
#(
   parameter int WIDTH = MUL_ADD_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     quotient,
   input  logic [WIDTH-1:0]     divisor,
   input  logic [WIDTH-1:0]     remainder,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 invalid
);

   state_t state;
   state_t state_next;
   logic   load;
   logic   step;
   logic   result_load;
   logic   last;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath controls.
   always_comb begin
      state_next  = state;
      load        = 1'b0;
      step        = 1'b0;
      result_load = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_next  = DONE;
               result_load = 1'b1;
            end
         end
         DONE: begin
            if (start) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   unsigned_mul_add_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .step        (step),
      .result_load (result_load),
      .quotient    (quotient),
      .divisor     (divisor),
      .remainder   (remainder),
      .last        (last),
      .result      (result)
   );

`ifdef MUL_ADD_CHECK_EN
   // Flag operands that no valid division could have produced; held until
   // the next accept or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         invalid <= 1'b0;
      end else if (load) begin
         invalid <= (divisor == '0) | (remainder >= divisor);
      end
   end
`else
   assign invalid = 1'b0;
`endif

endmodule

// File: tb/tb_unsigned_mul_add_seq.sv
// Self-checking bench for unsigned_mul_add_seq (WIDTH=8). Expected values come
// from plain integer arithmetic: q*d + r, and dividend / divisor splits.
module tb_unsigned_mul_add_seq;

  localparam int W = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic [W-1:0]    quotient;
  logic [W-1:0]    divisor;
  logic [W-1:0]    remainder;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  result;
  logic            invalid;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*W-1:0] exp_q[$];

  unsigned_mul_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .invalid   (invalid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [2*W-1:0] model_result(input int q, input int d, input int r);
    int v;
    v = q * d + r;
    return v[2*W-1:0];
  endfunction

  function automatic logic model_invalid(input int d, input int r);
`ifdef MUL_ADD_CHECK_EN
    return (d == 0) || (r >= d);
`else
    return 1'b0;
`endif
  endfunction

  // driver: accept an operation and wait until busy drops (bounded)
  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                        output int bcyc, output bit to);
    @(negedge clk);
    start = 1'b1; quotient = q; divisor = d; remainder = r;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    to = 1'b0;
    while (busy === 1'b1 && !to) begin
      bcyc++;
      if (bcyc > 4 * W) to = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; quotient = '0; divisor = '0; remainder = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got=%0d exp=0", result); end
    n_cmp++; if (invalid !== 1'b0) begin n_err++; $display("FAIL reset_invalid got=%b exp=0", invalid); end
    // start together with rst: rst wins
    start = 1'b1; quotient = 8'd3; divisor = 8'd3; remainder = 8'd0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_busy got=%b exp=0", busy); end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] tq[4] = '{8'd13, 8'd255, 8'd5, 8'hFF};
    logic [W-1:0] td[4] = '{8'd7,  8'd255, 8'd0, 8'd0};
    logic [W-1:0] tr[4] = '{8'd3,  8'd255, 8'd9, 8'hFF};
    logic [2*W-1:0] te[4] = '{16'd94, 16'hFF00, 16'd9, 16'h00FF};
    int bc; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(tq[i], td[i], tr[i], bc, to);
      n_cmp++; if (to) begin n_err++; $display("FAIL vec%0d_timeout busy never dropped", i); end
      n_cmp++; if (bc != W) begin n_err++; $display("FAIL vec%0d_busy_cycles got=%0d exp=%0d", i, bc, W); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL vec%0d_done got=%b exp=1", i, done); end
      n_cmp++; if (result !== te[i]) begin n_err++; $display("FAIL vec%0d_result got=%0d exp=%0d", i, result, te[i]); end
      n_cmp++; if (invalid !== model_invalid(td[i], tr[i])) begin n_err++; $display("FAIL vec%0d_invalid got=%b exp=%b", i, invalid, model_invalid(td[i], tr[i])); end
      // DONE holds with start low
      @(negedge clk);
      n_cmp++; if (done !== 1'b1 || result !== te[i]) begin n_err++; $display("FAIL vec%0d_hold done=%b result=%0d exp=1/%0d", i, done, result, te[i]); end
    end
  endtask

  task automatic test_ignore_and_restart();
    int bc;
    // accept 10*10+0
    @(negedge clk);
    start = 1'b1; quotient = 8'd10; divisor = 8'd10; remainder = 8'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    // busy cycle 3: try a second start with different operands
    start = 1'b1; quotient = 8'd1; divisor = 8'd1; remainder = 8'd1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc <= 4 * W) begin bc++; @(negedge clk); end
    n_cmp++; if (done !== 1'b1 || result !== 16'd100) begin n_err++; $display("FAIL ignore_result done=%b got=%0d exp=1/100", done, result); end
    // start in DONE
    @(negedge clk);
    start = 1'b1; quotient = 8'd1; divisor = 8'd1; remainder = 8'd1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL restart_flags done=%b busy=%b exp=0/1", done, busy); end
    bc = 0;
    while (busy === 1'b1 && bc <= 4 * W) begin
      n_cmp++; if (result !== 16'd100) begin n_err++; $display("FAIL restart_hold got=%0d exp=100", result); end
      bc++;
      @(negedge clk);
    end
    n_cmp++; if (bc != W) begin n_err++; $display("FAIL restart_busy_cycles got=%0d exp=%0d", bc, W); end
    n_cmp++; if (done !== 1'b1 || result !== 16'd2) begin n_err++; $display("FAIL restart_result done=%b got=%0d exp=1/2", done, result); end
  endtask

  task automatic test_rst_abort();
    int bc; bit to;
    @(negedge clk);
    start = 1'b1; quotient = 8'd200; divisor = 8'd3; remainder = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_flags busy=%b done=%b exp=0/0", busy, done); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL abort_result got=%0d exp=0", result); end
    n_cmp++; if (invalid !== 1'b0) begin n_err++; $display("FAIL abort_invalid got=%b exp=0", invalid); end
    run_op(8'd6, 8'd6, 8'd2, bc, to);
    n_cmp++; if (to || bc != W) begin n_err++; $display("FAIL abort_next_cycles got=%0d exp=%0d", bc, W); end
    n_cmp++; if (done !== 1'b1 || result !== 16'd38) begin n_err++; $display("FAIL abort_next_result done=%b got=%0d exp=1/38", done, result); end
  endtask

  task automatic test_random();
    int bc; bit to;
    logic [W-1:0] q, d, r;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 60; i++) begin
      q = W'($urandom_range(0, 255));
      d = (i % 7 == 0) ? '0 : W'($urandom_range(0, 255));
      r = W'($urandom_range(0, 255));
      exp_q.push_back(model_result(q, d, r));
      run_op(q, d, r, bc, to);
      exp = exp_q.pop_front();
      n_cmp++; if (to || done !== 1'b1) begin n_err++; $display("FAIL rand%0d_done done=%b timeout=%b", i, done, to); end
      n_cmp++; if (result !== exp) begin n_err++; $display("FAIL rand%0d_result q=%0d d=%0d r=%0d got=%0d exp=%0d", i, q, d, r, result, exp); end
      n_cmp++; if (invalid !== model_invalid(d, r)) begin n_err++; $display("FAIL rand%0d_invalid got=%b exp=%b", i, invalid, model_invalid(d, r)); end
    end
  endtask

  task automatic test_divider_loop();
    int bc; bit to;
    int dvd, dvs;
    for (int i = 0; i < 240; i++) begin
      if (i == 0) dvs = 1;
      else if (i == 1) dvs = 255;
      else dvs = $urandom_range(1, 255);
      if (i % 20 == 2) dvd = 256 * dvs - 1;
      else dvd = $urandom_range(0, 256 * dvs - 1);
      run_op(W'(dvd / dvs), W'(dvs), W'(dvd % dvs), bc, to);
      n_cmp++; if (to || result !== dvd[2*W-1:0]) begin n_err++; $display("FAIL div%0d_result dividend=%0d divisor=%0d got=%0d exp=%0d", i, dvd, dvs, result, dvd); end
      n_cmp++; if (invalid !== 1'b0) begin n_err++; $display("FAIL div%0d_invalid got=%b exp=0", i, invalid); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_and_restart();
    test_rst_abort();
    test_random();
    test_divider_loop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
